// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM state, port ids and default widths for the DMEM arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection; round-robin on ties with DMEM_ARB_RR_EN, else port 0 wins ties.
module dmem_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic win,
  output logic valid
);
  assign valid = req0 | req1;
`ifdef DMEM_ARB_RR_EN
  assign win = (req0 & req1) ? ~ptr : req1;
`else
  // ptr is tied to PORT_DMA here, so it only shapes win when no port requests
  assign win = ~req0 & (req1 | ptr);
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port DMEM; IDLE -> ACCESS -> RESP per access.
// Round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wrt0,
  input  logic              wrt1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_ctrl_rd,
  output logic              mem_ctrl_wrt,
  input  logic [DATA_W-1:0] mem_rd_data
);
  state_t state, state_nxt;
  logic win, valid, ptr, win_q, wrt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  dmem_arb_pick u_pick (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .win  (win),
    .valid(valid)
  );
`ifdef DMEM_ARB_RR_EN
  // last winner; resets to DMA so the first tie goes to the CPU
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= PORT_DMA;
    else if (state == ACCESS) ptr <= win_q;
`else
  assign ptr = PORT_DMA;
`endif
  always_comb begin
    state_nxt = IDLE;
    if (state == IDLE) state_nxt = valid ? ACCESS : IDLE;
    else if (state == ACCESS) state_nxt = RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q   <= PORT_CPU;
      wrt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && valid) begin
        win_q   <= win;
        wrt_q   <= win ? wrt1 : wrt0;
        addr_q  <= win ? addr1 : addr0;
        wdata_q <= win ? wdata1 : wdata0;
      end
      if (state == ACCESS && !wrt_q) rdata_q <= mem_rd_data;
    end
  assign gnt0         = state == ACCESS && win_q == PORT_CPU;
  assign gnt1         = state == ACCESS && win_q == PORT_DMA;
  assign done0        = state == RESP && win_q == PORT_CPU;
  assign done1        = state == RESP && win_q == PORT_DMA;
  assign busy         = state != IDLE;
  assign mem_ctrl_rd  = state == ACCESS && !wrt_q;
  assign mem_ctrl_wrt = state == ACCESS && wrt_q;
  assign mem_addr     = addr_q;
  assign mem_data     = wdata_q;
  assign rdata        = rdata_q;
endmodule
